// File: rtl/io_fifo_port.sv
// io_fifo_port: CPU-side I/O port.
//   Inbound : DEPTH-entry first-word-fall-through FIFO (device -> CPU).
//   Outbound: one-entry valid/ready holding register (CPU -> device).
//   irq     : level pending flag, raised by inbound pushes, cleared by irq_ack.
// Optional build macro IO_IRQ_THRESH_EN: when defined, irq is raised only by a
// push that brings the fill level to IRQ_THRESH or above.
module io_fifo_port #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 8,
    parameter int IRQ_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          ext_in_data,
    input  logic                       ext_in_valid,
    output logic                       ext_in_ready,
    input  logic                       cpu_rd_en,
    output logic [DATA_W-1:0]          cpu_rd_data,
    output logic                       cpu_in_empty,
    output logic [$clog2(DEPTH):0]     in_count,
    input  logic                       cpu_wr_en,
    input  logic [DATA_W-1:0]          cpu_wr_data,
    output logic                       cpu_out_busy,
    output logic [DATA_W-1:0]          ext_out_data,
    output logic                       ext_out_valid,
    input  logic                       ext_out_ready,
    output logic                       irq,
    input  logic                       irq_ack,
    output logic                       ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Elaboration-time sanity checks on the configuration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("io_fifo_port: DEPTH must be a power of 2 and at least 2");
    end
    if ((IRQ_THRESH < 1) || (IRQ_THRESH > DEPTH)) begin : g_bad_thresh
        $error("io_fifo_port: IRQ_THRESH must lie in 1..DEPTH");
    end

    // Inbound FIFO state
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic              push_s;
    logic              pop_s;

    // Outbound holding register and status state
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_busy_s;
    logic              out_load_s;
    logic              out_drain_s;
    logic              ovf_r;
    logic              irq_r;
    logic              irq_set_s;

    // Handshake decode: a pop on an empty FIFO is simply not a pop.
    assign ext_in_ready = (count_r != CNT_W'(DEPTH));
    assign push_s       = ext_in_valid && ext_in_ready;
    assign pop_s        = cpu_rd_en && (count_r != {CNT_W{1'b0}});

    assign cpu_in_empty = (count_r == {CNT_W{1'b0}});
    assign in_count     = count_r;
    assign cpu_rd_data  = mem_r[rd_ptr_r];

    // Outbound decode: a draining register can accept a new word in the same cycle.
    assign out_busy_s   = out_valid_r && !ext_out_ready;
    assign out_load_s   = cpu_wr_en && !out_busy_s;
    assign out_drain_s  = out_valid_r && ext_out_ready;
    assign cpu_out_busy = out_busy_s;
    assign ext_out_data = out_data_r;
    assign ext_out_valid = out_valid_r;
    assign ovf          = ovf_r;
    assign irq          = irq_r;

    // Next fill level; push and pop together leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Interrupt set condition for the current cycle.
    always_comb begin
        irq_set_s = 1'b0;
`ifdef IO_IRQ_THRESH_EN
        if (push_s && (count_next_s >= CNT_W'(IRQ_THRESH))) begin
            irq_set_s = 1'b1;
        end else begin
            irq_set_s = 1'b0;
        end
`else
        if (push_s) begin
            irq_set_s = 1'b1;
        end else begin
            irq_set_s = 1'b0;
        end
`endif
    end

    // FIFO storage write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= ext_in_data;
        end
    end

    // FIFO pointers and fill level; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Outbound holding register; data only changes on an accepted CPU write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (out_load_s) begin
            out_data_r  <= cpu_wr_data;
            out_valid_r <= 1'b1;
        end else if (out_drain_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky overflow: a CPU write arrived while the register was stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (cpu_wr_en && out_busy_s) begin
            ovf_r <= 1'b1;
        end
    end

    // Interrupt pending flag; a new set beats a coincident acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_r <= 1'b1;
        end else if (irq_ack) begin
            irq_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_fifo_port.sv
// Directed bench for io_fifo_port (DEPTH=8). Inbound words are pushed into a
// scoreboard queue as they are offered and popped/compared as the CPU reads.
module tb_io_fifo_port;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int THRESH = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic              cpu_rd_en;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_in_empty;
    logic [3:0]        in_count;
    logic              cpu_wr_en;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_out_busy;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic              irq;
    logic              irq_ack;
    logic              ovf;

    int tests;
    int fails;
    logic [DATA_W-1:0] sb_q[$];

    io_fifo_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IRQ_THRESH(THRESH)) dut (
        .clk(clk), .rst(rst),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data), .cpu_in_empty(cpu_in_empty),
        .in_count(in_count),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data), .cpu_out_busy(cpu_out_busy),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .irq(irq), .irq_ack(irq_ack), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        check("push_ready", 32'(ext_in_ready), 32'd1);
        ext_in_data  = w;
        ext_in_valid = 1'b1;
        sb_q.push_back(w);
        step();
        ext_in_valid = 1'b0;
    endtask

    task automatic pop_word();
        logic [DATA_W-1:0] exp;
        exp = sb_q.pop_front();
        check("pop_nonempty", 32'(cpu_in_empty), 32'd0);
        check("pop_data", 32'(cpu_rd_data), 32'(exp));
        cpu_rd_en = 1'b1;
        step();
        cpu_rd_en = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_w;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        ext_in_data = 16'h0000; ext_in_valid = 1'b0; cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0; cpu_wr_data = 16'h0000; ext_out_ready = 1'b0; irq_ack = 1'b0;
        #3;
        check("rst_count", 32'(in_count), 32'd0);
        check("rst_empty", 32'(cpu_in_empty), 32'd1);
        check("rst_in_ready", 32'(ext_in_ready), 32'd1);
        check("rst_out_valid", 32'(ext_out_valid), 32'd0);
        check("rst_out_data", 32'(ext_out_data), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // ---- reset mid-traffic: 3 words in, outbound stalled with ovf set
        push_word(16'h0101);
        push_word(16'h0202);
        push_word(16'h0303);
        cpu_wr_en = 1'b1; cpu_wr_data = 16'hBEEF;
        step();
        step();
        cpu_wr_en = 1'b0;
        check("pre_rst_count", 32'(in_count), 32'd3);
        check("pre_rst_ovf", 32'(ovf), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(in_count), 32'd0);
        check("mid_rst_empty", 32'(cpu_in_empty), 32'd1);
        check("mid_rst_out_valid", 32'(ext_out_valid), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b1;
        sb_q.delete();
        step();

        // ---- fill to full, then wrap
        for (int i = 1; i <= DEPTH; i++) push_word(DATA_W'(i));
        check("full_count", 32'(in_count), 32'd8);
        check("full_ready", 32'(ext_in_ready), 32'd0);
        ext_in_valid = 1'b1; ext_in_data = 16'hDEAD;
        step();
        ext_in_valid = 1'b0;
        check("full_hold_count", 32'(in_count), 32'd8);
        for (int i = 0; i < 3; i++) pop_word();
        for (int i = 9; i <= 11; i++) push_word(DATA_W'(i));
        check("wrap_head", 32'(cpu_rd_data), 32'h0004);
        while (sb_q.size() > 0) pop_word();
        check("wrap_empty", 32'(cpu_in_empty), 32'd1);
        check("wrap_count", 32'(in_count), 32'd0);

        // ---- simultaneous push+pop at level 5
        for (int i = 0; i < 5; i++) push_word(16'h0010 + DATA_W'(i));
        for (int i = 0; i < 4; i++) begin
            exp_w = sb_q.pop_front();
            check("pp_data", 32'(cpu_rd_data), 32'(exp_w));
            ext_in_data = 16'h0020 + DATA_W'(i);
            ext_in_valid = 1'b1;
            cpu_rd_en = 1'b1;
            sb_q.push_back(ext_in_data);
            step();
            check("pp_count", 32'(in_count), 32'd5);
        end
        ext_in_valid = 1'b0; cpu_rd_en = 1'b0;
        while (sb_q.size() > 0) pop_word();
        // pop on empty with a push in the same cycle
        ext_in_data = 16'h0077; ext_in_valid = 1'b1; cpu_rd_en = 1'b1;
        sb_q.push_back(16'h0077);
        step();
        ext_in_valid = 1'b0; cpu_rd_en = 1'b0;
        check("empty_pp_count", 32'(in_count), 32'd1);
        pop_word();
        check("empty_pp_drained", 32'(in_count), 32'd0);

        // ---- outbound backpressure
        ext_out_ready = 1'b0;
        cpu_wr_en = 1'b1; cpu_wr_data = 16'hA5A5;
        step();
        cpu_wr_en = 1'b0;
        check("out_valid1", 32'(ext_out_valid), 32'd1);
        check("out_busy1", 32'(cpu_out_busy), 32'd1);
        check("out_data1", 32'(ext_out_data), 32'hA5A5);
        check("ovf_clear", 32'(ovf), 32'd0);
        cpu_wr_en = 1'b1; cpu_wr_data = 16'h5A5A;
        step();
        cpu_wr_en = 1'b0;
        check("ovf_set", 32'(ovf), 32'd1);
        check("out_data_held", 32'(ext_out_data), 32'hA5A5);
        check("out_valid_held", 32'(ext_out_valid), 32'd1);
        ext_out_ready = 1'b1; cpu_wr_en = 1'b1; cpu_wr_data = 16'h1234;
        #1;
        check("out_busy_drain", 32'(cpu_out_busy), 32'd0);
        step();
        cpu_wr_en = 1'b0;
        check("out_data2", 32'(ext_out_data), 32'h1234);
        check("out_valid2", 32'(ext_out_valid), 32'd1);
        step();
        check("out_drained", 32'(ext_out_valid), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);
        ext_out_ready = 1'b0;

        // ---- irq: start from a cleared flag and empty FIFO
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("irq_pre_clear", 32'(irq), 32'd0);
`ifdef IO_IRQ_THRESH_EN
        for (int i = 1; i <= 3; i++) begin
            push_word(16'h0030 + DATA_W'(i));
            check("irq_below_thresh", 32'(irq), 32'd0);
        end
        push_word(16'h0034);
        check("irq_at_thresh", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("irq_ack", 32'(irq), 32'd0);
        push_word(16'h0035);
        check("irq_above_thresh", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        push_word(16'h0036);
        irq_ack = 1'b0;
        check("irq_ack_vs_push", 32'(irq), 32'd1);
`else
        push_word(16'h0031);
        check("irq_push", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("irq_ack", 32'(irq), 32'd0);
        irq_ack = 1'b1;
        push_word(16'h0032);
        irq_ack = 1'b0;
        check("irq_ack_vs_push", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step();
        step();
        irq_ack = 1'b0;
        check("irq_ack_idle", 32'(irq), 32'd0);
`endif
        while (sb_q.size() > 0) pop_word();
        check("final_empty", 32'(cpu_in_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_fifo_port.md
Name: io_fifo_port

Overview:
- Parametrised successor to the CPU's bare 16-bit in_port/out_port pair.
- Sits between the CPU's I/O instructions and an external device.
- Buffers inbound words in a DEPTH-entry first-word-fall-through FIFO and drives outbound words through a one-entry valid/ready holding register.
- Raises an interrupt request to the CPU's interrupt logic when inbound data arrives.

Parameters:
- DATA_W, 16, width of every data word.
- DEPTH, 8, inbound FIFO entries; must be a power of 2 and at least 2.
- IRQ_THRESH, 4, inbound fill level that raises irq; used only with IO_IRQ_THRESH_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ext_in_data  in  DATA_W  inbound word from the device.
- ext_in_valid  in  1  inbound word valid.
- ext_in_ready  out  1  FIFO can accept a word.
- cpu_rd_en  in  1  CPU pops the FIFO head.
- cpu_rd_data  out  DATA_W  FIFO head word.
- cpu_in_empty  out  1  FIFO empty.
- in_count  out  $clog2(DEPTH)+1  current FIFO fill level.
- cpu_wr_en  in  1  CPU writes an outbound word.
- cpu_wr_data  in  DATA_W  outbound word.
- cpu_out_busy  out  1  holding register occupied and not draining this cycle.
- ext_out_data  out  DATA_W  outbound word to the device.
- ext_out_valid  out  1  outbound word valid.
- ext_out_ready  in  1  device accepts the outbound word.
- irq  out  1  interrupt request, level.
- irq_ack  in  1  CPU acknowledges the interrupt.
- ovf  out  1  sticky flag: a CPU write was dropped.

Behaviour:
- Reset (rst=0, asynchronous): read/write pointers=0, in_count=0, cpu_in_empty=1, ext_in_ready=1, ext_out_valid=0, ext_out_data=0, irq=0, ovf=0. cpu_rd_data is don't-care while empty. FIFO storage is not cleared. Release is synchronous to clk.
- Push: on ext_in_valid && ext_in_ready. ext_in_ready = (in_count != DEPTH), combinational.
- Pop: on cpu_rd_en && !cpu_in_empty. A pop while empty is ignored; no state changes.
- cpu_rd_data presents the head combinationally (zero-latency FWFT). A word pushed at edge N is visible at cpu_rd_data after edge N.
- Push and pop in the same cycle: in_count unchanged, both pointers advance.
- Push into an empty FIFO with cpu_rd_en high in the same cycle: the pop is ignored and the push proceeds.
- When full, ready=0, so a same-cycle pop does not admit the waiting word until the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. in_count saturates by construction, never exceeding DEPTH.
- Outbound register:
  - cpu_out_busy = ext_out_valid && !ext_out_ready.
  - cpu_wr_en && !cpu_out_busy loads ext_out_data and sets ext_out_valid=1 at the next edge. This includes back-to-back writes while the device drains every cycle.
  - ext_out_valid && ext_out_ready && !cpu_wr_en clears ext_out_valid.
  - cpu_wr_en while cpu_out_busy drops the word, leaves the register unchanged and sets ovf=1. ovf clears only on reset.
  - ext_out_data is stable while ext_out_valid && !ext_out_ready.
- irq is a registered pending flag:
  - Set at the edge after any accepted push.
  - Cleared at the edge after irq_ack.
  - Push and irq_ack in the same cycle: set wins, irq stays 1.
  - irq_ack while irq=0 has no effect.

Optional Feature:
- Macro IO_IRQ_THRESH_EN.
- Defined: irq is set only at an accepted push that makes in_count reach a value at or above IRQ_THRESH (compared after the push). Pushes below the threshold leave irq unchanged. Ack and set priority are as above.
- Undefined: IRQ_THRESH is ignored and irq sets on every accepted push.

Test Plan:
- Reset mid-traffic: fill 3 words, drive rst=0 for 1 cycle between edges -> immediately in_count=0, cpu_in_empty=1, ext_out_valid=0, irq=0, ovf=0.
- Fill/drain wrap: push 0x0001..0x0008 (DEPTH=8) -> ext_in_ready=0 at in_count=8. Pop 3, push 0x0009..0x000B -> pops return 0x0004..0x000B in order, then cpu_in_empty=1.
- Simultaneous push+pop at in_count=5 for 4 cycles -> in_count stays 5 and data order is preserved. Pop on empty with ext_in_valid=1 -> in_count becomes 1.
- Outbound backpressure: write 0xA5A5 with ext_out_ready=0 -> ext_out_valid=1, cpu_out_busy=1. A second write of 0x5A5A -> dropped, ovf=1, data still 0xA5A5. Raise ready with a write of 0x1234 in the same cycle -> next data is 0x1234, valid=1.
- irq: push one word -> irq=1 next cycle. Ack alone -> irq=0. Ack coincident with a push -> irq stays 1.
- With IO_IRQ_THRESH_EN and IRQ_THRESH=4: pushes 1-3 -> irq=0. Push 4 -> irq=1. Ack then push 5 -> irq=1 again.
